float_operand_join: RTL and testbench
=====================================

FLOAT_OPERAND_JOIN -- requirements
Module: float_operand_join

Interface
REQ-001 Parameter SIZE, default 32, SHALL set the operand width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the per-channel buffer entries; legal values are powers of two, at least 2.
REQ-003 aclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 aresetn  input  1  SHALL be the synchronous, active-high reset (asserted = 1, despite the suffix).
REQ-005 s_axis_a_tdata / s_axis_b_tdata / s_axis_c_tdata  input  SIZE  SHALL carry the operand beats for channels a, b and c.
REQ-006 s_axis_a_tvalid / s_axis_b_tvalid / s_axis_c_tvalid  input  1  SHALL each qualify the tdata of the same channel.
REQ-007 s_axis_a_tready / s_axis_b_tready / s_axis_c_tready  output  1  SHALL each indicate that the channel accepts a beat this cycle.
REQ-008 m_axis_a_tdata / m_axis_b_tdata / m_axis_c_tdata  output  SIZE  SHALL carry the joined operand triple.
REQ-009 m_axis_a_tvalid / m_axis_b_tvalid / m_axis_c_tvalid  output  1  SHALL be identical copies of one internal output-valid bit.
REQ-010 m_axis_a_tready / m_axis_b_tready / m_axis_c_tready  input  1  SHALL be the downstream readies; out_ready is the AND of all three.
REQ-011 joined_count  output  32  SHALL count completed output transfers.

Function
REQ-012 Each channel SHALL have an independent in-order FIFO of DEPTH entries with an occupancy counter (0..DEPTH) and wrapping read/write pointers.
REQ-013 s_axis_x_tready SHALL equal (occupancy_x < DEPTH) and SHALL be derived from registered state only; there is no same-cycle pop bypass.
REQ-014 A channel write SHALL occur on a cycle where s_axis_x_tvalid and s_axis_x_tready are both 1; the data is stored at wr_ptr_x, and wr_ptr_x wraps DEPTH-1 -> 0.
REQ-015 The output stage SHALL be one register holding {a,b,c} plus out_valid.
REQ-016 A join SHALL fire when all three FIFOs are non-empty and (out_valid == 0 or out_ready == 1).
REQ-017 A join SHALL pop one entry from each FIFO in the same cycle and load the output register; a join never pops a partial triple.
REQ-018 out_valid SHALL set on a join, clear on (out_valid & out_ready & no join), and stay set on a simultaneous transfer plus join.
REQ-019 m_axis data and valid SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-020 Latency: beats accepted on all three channels at edge N SHALL appear with m_axis_*_tvalid = 1 in the cycle after edge N+1 (2 cycles), given an empty block and out_ready = 1.
REQ-021 Throughput SHALL be one triple per cycle when all inputs are valid and out_ready stays 1.
REQ-022 Ordering SHALL be the k-th output triple = the k-th accepted beat of a, of b and of c, regardless of arrival skew between channels.
REQ-023 Skew tolerance: one channel SHALL be able to run up to DEPTH beats ahead before its tready drops; the other channels are unaffected.
REQ-024 A simultaneous write and pop on one channel SHALL leave occupancy unchanged; when occupancy = 0, only a write can occur.
REQ-025 joined_count SHALL increment by 1 on each cycle with out_valid & out_ready and wrap 0xFFFFFFFF -> 0.
REQ-026 The block SHALL NOT inspect or modify operand values; data passes bit-exact.

Reset
REQ-027 While aresetn = 1: all s_axis_*_tready = 0 and all m_axis_*_tvalid = 0.
REQ-028 On reset: occupancies, pointers and joined_count SHALL be 0; out_valid = 0; m_axis tdata = 0.
REQ-029 Reset mid-operation SHALL discard all buffered and output-register data; no stale beat may be emitted after reset.
REQ-030 On the first cycle after aresetn returns to 0, all s_axis_*_tready SHALL be 1.

Verification
REQ-031 Single triple: a=0x3F800000, b=0x40000000, c=0x40400000 presented at edge 0, out_ready = 1 -> the same triple appears on m_axis in cycle 2 with tvalid = 1 for one cycle; joined_count = 1.
REQ-032 Skew: a sends 4 beats 1..4 while b and c are idle -> s_axis_a_tready = 0 after the 4th beat and m tvalid stays 0; b and c then send 1..4 -> outputs (1,1,1)..(4,4,4) in order.
REQ-033 Backpressure: stream 10 triples with out_ready = 0 for cycles 3-8 -> output held stable, input readies drop once the FIFOs are full, and all 10 triples arrive in order with none lost or duplicated.
REQ-034 Full throughput: 100 back-to-back triples with out_ready = 1 -> 100 consecutive output cycles, joined_count = 100.
REQ-035 Mid-run reset: assert aresetn for 1 cycle with 3 triples buffered -> tvalid = 0, no old data emitted, and the next triple sent is the first output.
REQ-036 Counter wrap: preload or force joined_count = 0xFFFFFFFF, then complete one transfer -> joined_count = 0.

Source files
------------

// File: rtl/float_operand_join_if.sv
// Stream bundle for float_operand_join: three operand input channels (a, b, c)
// and the joined operand triple output. The slave modport is the join block's
// view; the master modport is the view of whatever drives and consumes it.
interface float_operand_join_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] s_axis_a_tdata;
    logic [SIZE-1:0] s_axis_b_tdata;
    logic [SIZE-1:0] s_axis_c_tdata;
    logic            s_axis_a_tvalid;
    logic            s_axis_b_tvalid;
    logic            s_axis_c_tvalid;
    logic            s_axis_a_tready;
    logic            s_axis_b_tready;
    logic            s_axis_c_tready;

    logic [SIZE-1:0] m_axis_a_tdata;
    logic [SIZE-1:0] m_axis_b_tdata;
    logic [SIZE-1:0] m_axis_c_tdata;
    logic            m_axis_a_tvalid;
    logic            m_axis_b_tvalid;
    logic            m_axis_c_tvalid;
    logic            m_axis_a_tready;
    logic            m_axis_b_tready;
    logic            m_axis_c_tready;

    modport slave (
        input  s_axis_a_tdata, s_axis_b_tdata, s_axis_c_tdata,
        input  s_axis_a_tvalid, s_axis_b_tvalid, s_axis_c_tvalid,
        output s_axis_a_tready, s_axis_b_tready, s_axis_c_tready,
        output m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata,
        output m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid,
        input  m_axis_a_tready, m_axis_b_tready, m_axis_c_tready
    );

    modport master (
        output s_axis_a_tdata, s_axis_b_tdata, s_axis_c_tdata,
        output s_axis_a_tvalid, s_axis_b_tvalid, s_axis_c_tvalid,
        input  s_axis_a_tready, s_axis_b_tready, s_axis_c_tready,
        input  m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata,
        input  m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid,
        output m_axis_a_tready, m_axis_b_tready, m_axis_c_tready
    );
endinterface

// File: rtl/float_operand_join.sv
// float_operand_join: buffers three independent operand streams in per-channel
// FIFOs and emits them as aligned triples through a single output register.
// The k-th output triple is always the k-th beat accepted on each channel, so
// channels may arrive with arbitrary skew (up to DEPTH beats per channel).
// Operand values are never inspected; data passes through bit-exact.
// Note: aresetn is a synchronous reset that is active HIGH despite its name.
module float_operand_join #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    float_operand_join_if.slave  axis,
    output logic [31:0]          joined_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Channel index 0 = a, 1 = b, 2 = c throughout.
    logic [SIZE-1:0]  in_data  [3];
    logic [2:0]       in_valid;
    logic [2:0]       in_ready;
    logic [2:0]       push;

    logic [SIZE-1:0]  fifo_mem [3][DEPTH];
    logic [PTR_W-1:0] wr_ptr   [3];
    logic [PTR_W-1:0] rd_ptr   [3];
    logic [OCC_W-1:0] occ      [3];

    logic [SIZE-1:0]  out_data [3];
    logic             out_valid;
    logic             out_ready;
    logic             all_nonempty;
    logic             do_join;
    logic             do_xfer;

    // Gather the channels into arrays and decide this cycle's writes, join and transfer.
    always_comb begin
        in_data[0] = axis.s_axis_a_tdata;
        in_data[1] = axis.s_axis_b_tdata;
        in_data[2] = axis.s_axis_c_tdata;
        in_valid   = {axis.s_axis_c_tvalid, axis.s_axis_b_tvalid, axis.s_axis_a_tvalid};
        out_ready  = axis.m_axis_a_tready & axis.m_axis_b_tready & axis.m_axis_c_tready;
        in_ready   = '0;
        push       = '0;
        for (int i = 0; i < 3; i++) begin
            // Readiness looks only at stored occupancy; a pop this cycle does not free a slot early.
            in_ready[i] = ~aresetn & (occ[i] != OCC_FULL);
            push[i]     = in_valid[i] & in_ready[i];
        end
        all_nonempty = (occ[0] != '0) & (occ[1] != '0) & (occ[2] != '0);
        do_join      = all_nonempty & (~out_valid | out_ready);
        do_xfer      = out_valid & out_ready;
    end

    assign axis.s_axis_a_tready = in_ready[0];
    assign axis.s_axis_b_tready = in_ready[1];
    assign axis.s_axis_c_tready = in_ready[2];

    assign axis.m_axis_a_tdata  = out_data[0];
    assign axis.m_axis_b_tdata  = out_data[1];
    assign axis.m_axis_c_tdata  = out_data[2];

    // The output valid is masked while reset is held so nothing leaks out during the reset cycle.
    assign axis.m_axis_a_tvalid = out_valid & ~aresetn;
    assign axis.m_axis_b_tvalid = out_valid & ~aresetn;
    assign axis.m_axis_c_tvalid = out_valid & ~aresetn;

    // FIFO storage needs no reset: occupancy guarantees stale entries are never read.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    // Pointers, occupancies, output register and transfer counter.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                occ[i]      <= '0;
                out_data[i] <= '0;
            end
            out_valid    <= 1'b0;
            joined_count <= 32'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= (wr_ptr[i] == PTR_LAST) ? '0 : wr_ptr[i] + PTR_W'(1);
                end
                if (do_join) begin
                    rd_ptr[i]   <= (rd_ptr[i] == PTR_LAST) ? '0 : rd_ptr[i] + PTR_W'(1);
                    out_data[i] <= fifo_mem[i][rd_ptr[i]];
                end
                if (push[i] && !do_join) begin
                    occ[i] <= occ[i] + OCC_W'(1);
                end else if (!push[i] && do_join) begin
                    occ[i] <= occ[i] - OCC_W'(1);
                end
            end
            if (do_join) begin
                out_valid <= 1'b1;
            end else if (do_xfer) begin
                out_valid <= 1'b0;
            end
            if (do_xfer) begin
                joined_count <= joined_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_float_operand_join.sv
// Testbench for float_operand_join: a queue-based behavioural model predicts
// readies, output valid, output data and the transfer count every cycle;
// directed scenarios pin the model with hand-computed literal expectations.
module tb_float_operand_join;

    localparam int SIZE  = 32;
    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] joined_count;

    int total     = 0;
    int bad       = 0;
    int cycle_num = 0;

    float_operand_join_if #(.SIZE(SIZE)) bus ();

    float_operand_join #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .axis         (bus.slave),
        .joined_count (joined_count)
    );

    always #5 aclk = ~aclk;

    // Behavioural model state: accepted-but-not-joined beats per channel plus the output stage.
    logic [SIZE-1:0] mq_a [$];
    logic [SIZE-1:0] mq_b [$];
    logic [SIZE-1:0] mq_c [$];
    logic [SIZE-1:0] m_out_a = '0;
    logic [SIZE-1:0] m_out_b = '0;
    logic [SIZE-1:0] m_out_c = '0;
    bit              m_valid = 1'b0;
    logic [31:0]     m_count = 32'd0;
    logic [31:0]     count_bias = 32'd0;

    // Observed output transfers, oldest first, with the cycle they happened on.
    logic [3*SIZE-1:0] obs [$];
    int                obs_cyc [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic modelStep();
        bit ordy, acc_a, acc_b, acc_c, jn, xf;
        if (aresetn) begin
            mq_a.delete();
            mq_b.delete();
            mq_c.delete();
            m_out_a = '0;
            m_out_b = '0;
            m_out_c = '0;
            m_valid = 1'b0;
            m_count = 32'd0;
        end else begin
            ordy  = bus.m_axis_a_tready && bus.m_axis_b_tready && bus.m_axis_c_tready;
            acc_a = bus.s_axis_a_tvalid && (mq_a.size() < DEPTH);
            acc_b = bus.s_axis_b_tvalid && (mq_b.size() < DEPTH);
            acc_c = bus.s_axis_c_tvalid && (mq_c.size() < DEPTH);
            jn    = (mq_a.size() > 0) && (mq_b.size() > 0) && (mq_c.size() > 0) && (!m_valid || ordy);
            xf    = m_valid && ordy;
            if (xf) m_count = m_count + 32'd1;
            if (acc_a) mq_a.push_back(bus.s_axis_a_tdata);
            if (acc_b) mq_b.push_back(bus.s_axis_b_tdata);
            if (acc_c) mq_c.push_back(bus.s_axis_c_tdata);
            if (jn) begin
                m_out_a = mq_a.pop_front();
                m_out_b = mq_b.pop_front();
                m_out_c = mq_c.pop_front();
                m_valid = 1'b1;
            end else if (xf) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Advance the model on every rising edge using the inputs that edge sampled.
    initial forever begin
        @(posedge aclk);
        modelStep();
    end

    // Record every completed output transfer as seen on the bus.
    initial forever begin
        @(posedge aclk);
        cycle_num++;
        if (bus.m_axis_a_tvalid && bus.m_axis_a_tready && bus.m_axis_b_tready && bus.m_axis_c_tready) begin
            obs.push_back({bus.m_axis_a_tdata, bus.m_axis_b_tdata, bus.m_axis_c_tdata});
            obs_cyc.push_back(cycle_num);
        end
    end

    // Compare every DUT output against the model on the falling edge.
    initial forever begin
        bit exp_ra, exp_rb, exp_rc, exp_v;
        @(negedge aclk);
        exp_ra = !aresetn && (mq_a.size() < DEPTH);
        exp_rb = !aresetn && (mq_b.size() < DEPTH);
        exp_rc = !aresetn && (mq_c.size() < DEPTH);
        exp_v  = m_valid && !aresetn;
        checkOutput("a_tready", 32'(bus.s_axis_a_tready), 32'(exp_ra));
        checkOutput("b_tready", 32'(bus.s_axis_b_tready), 32'(exp_rb));
        checkOutput("c_tready", 32'(bus.s_axis_c_tready), 32'(exp_rc));
        checkOutput("a_tvalid", 32'(bus.m_axis_a_tvalid), 32'(exp_v));
        checkOutput("b_tvalid", 32'(bus.m_axis_b_tvalid), 32'(exp_v));
        checkOutput("c_tvalid", 32'(bus.m_axis_c_tvalid), 32'(exp_v));
        checkOutput("a_tdata", bus.m_axis_a_tdata, m_out_a);
        checkOutput("b_tdata", bus.m_axis_b_tdata, m_out_b);
        checkOutput("c_tdata", bus.m_axis_c_tdata, m_out_c);
        checkOutput("joined_count", joined_count, m_count + count_bias);
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input bit rst, input bit va, input bit vb, input bit vc,
                                 input logic [31:0] da, input logic [31:0] db, input logic [31:0] dc,
                                 input logic [2:0] ordy, output bit acc_a, output bit acc_b, output bit acc_c);
        @(negedge aclk);
        #1;
        aresetn             = rst;
        bus.s_axis_a_tvalid = va;
        bus.s_axis_b_tvalid = vb;
        bus.s_axis_c_tvalid = vc;
        bus.s_axis_a_tdata  = da;
        bus.s_axis_b_tdata  = db;
        bus.s_axis_c_tdata  = dc;
        bus.m_axis_a_tready = ordy[0];
        bus.m_axis_b_tready = ordy[1];
        bus.m_axis_c_tready = ordy[2];
        #1;
        acc_a = va && bus.s_axis_a_tready;
        acc_b = vb && bus.s_axis_b_tready;
        acc_c = vc && bus.s_axis_c_tready;
    endtask

    task automatic idle(input int n, input logic [2:0] ordy);
        bit x, y, z;
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, ordy, x, y, z);
    endtask

    task automatic doReset();
        bit x, y, z;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 3'b111, x, y, z);
    endtask

    // Stream n triples (base+i on every channel), holding each beat until accepted;
    // the output readies are low for stream cycles stall_lo..stall_hi.
    task automatic sendTriples(input int n, input logic [31:0] base, input int stall_lo, input int stall_hi,
                               output bit saw_full);
        int ia = 0;
        int ib = 0;
        int ic = 0;
        int k  = 0;
        bit x, y, z;
        logic [2:0] ordy;
        saw_full = 1'b0;
        while ((ia < n || ib < n || ic < n) && k < 400) begin
            ordy = (k >= stall_lo && k <= stall_hi) ? 3'b000 : 3'b111;
            applyStimulus(1'b0, ia < n, ib < n, ic < n, base + 32'(ia), base + 32'(ib), base + 32'(ic), ordy, x, y, z);
            if (ia < n && !bus.s_axis_a_tready) saw_full = 1'b1;
            if (x) ia++;
            if (y) ib++;
            if (z) ic++;
            k++;
        end
        checkOutput("send_all_a", 32'(ia), 32'(n));
        checkOutput("send_all_c", 32'(ic), 32'(n));
    endtask

    task automatic checkObs(input string name, input int idx, input logic [31:0] ea,
                            input logic [31:0] eb, input logic [31:0] ec);
        logic [3*SIZE-1:0] t;
        t = (idx < obs.size()) ? obs[idx] : '1;
        checkOutput({name, "_a"}, t[95:64], ea);
        checkOutput({name, "_b"}, t[63:32], eb);
        checkOutput({name, "_c"}, t[31:0], ec);
    endtask

    initial begin
        bit x, y, z, saw;
        int base;
        aresetn             = 1'b1;
        bus.s_axis_a_tvalid = 1'b0;
        bus.s_axis_b_tvalid = 1'b0;
        bus.s_axis_c_tvalid = 1'b0;
        bus.s_axis_a_tdata  = '0;
        bus.s_axis_b_tdata  = '0;
        bus.s_axis_c_tdata  = '0;
        bus.m_axis_a_tready = 1'b1;
        bus.m_axis_b_tready = 1'b1;
        bus.m_axis_c_tready = 1'b1;

        // Reset state
        doReset();
        doReset();
        checkOutput("reset_a_tready", 32'(bus.s_axis_a_tready), 32'd0);
        checkOutput("reset_tvalid", 32'(bus.m_axis_a_tvalid), 32'd0);
        checkOutput("reset_count", joined_count, 32'd0);
        checkOutput("reset_tdata", bus.m_axis_b_tdata, 32'd0);

        // Single triple, two-cycle latency
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b111, x, y, z);
        checkOutput("post_reset_a_tready", 32'(bus.s_axis_a_tready), 32'd1);
        checkOutput("post_reset_c_tready", 32'(bus.s_axis_c_tready), 32'd1);
        idle(1, 3'b111);
        checkOutput("lat_not_early", 32'(bus.m_axis_a_tvalid), 32'd0);
        idle(1, 3'b111);
        checkOutput("lat_tvalid", 32'(bus.m_axis_c_tvalid), 32'd1);
        checkOutput("lat_a", bus.m_axis_a_tdata, 32'h3F800000);
        checkOutput("lat_b", bus.m_axis_b_tdata, 32'h40000000);
        checkOutput("lat_c", bus.m_axis_c_tdata, 32'h40400000);
        idle(1, 3'b111);
        checkOutput("single_tvalid_drop", 32'(bus.m_axis_a_tvalid), 32'd0);
        checkOutput("single_count", joined_count, 32'd1);

        // Skew: a runs four beats ahead
        doReset();
        base = obs.size();
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'(i), 32'd0, 32'd0, 3'b111, x, y, z);
        idle(1, 3'b111);
        checkOutput("skew_a_full", 32'(bus.s_axis_a_tready), 32'd0);
        checkOutput("skew_b_ready", 32'(bus.s_axis_b_tready), 32'd1);
        checkOutput("skew_no_out", 32'(bus.m_axis_a_tvalid), 32'd0);
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'(i), 32'(i), 3'b111, x, y, z);
        idle(4, 3'b111);
        checkOutput("skew_out_count", 32'(obs.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            checkObs("skew_out", base + i, 32'(i + 1), 32'(i + 1), 32'(i + 1));

        // Backpressure
        doReset();
        base = obs.size();
        sendTriples(10, 32'h100, 3, 8, saw);
        idle(8, 3'b111);
        checkOutput("bp_ready_dropped", 32'(saw), 32'd1);
        checkOutput("bp_out_count", 32'(obs.size() - base), 32'd10);
        for (int i = 0; i < 10; i++)
            checkObs("bp_out", base + i, 32'h100 + 32'(i), 32'h100 + 32'(i), 32'h100 + 32'(i));

        // Full throughput
        doReset();
        base = obs.size();
        sendTriples(100, 32'h1000, -1, -1, saw);
        idle(4, 3'b111);
        checkOutput("tp_out_count", 32'(obs.size() - base), 32'd100);
        checkOutput("tp_joined_count", joined_count, 32'd100);
        checkOutput("tp_consecutive", 32'(obs_cyc[obs_cyc.size() - 1] - obs_cyc[base]), 32'd99);
        for (int i = 0; i < 100; i += 9)
            checkObs("tp_out", base + i, 32'h1000 + 32'(i), 32'h1000 + 32'(i), 32'h1000 + 32'(i));

        // Mid-run reset with three triples buffered
        doReset();
        sendTriples(3, 32'h500, 0, 1000, saw);
        idle(2, 3'b000);
        doReset();
        base = obs.size();
        for (int i = 0; i < 3; i++) begin
            idle(1, 3'b111);
            checkOutput("mrst_tvalid", 32'(bus.m_axis_a_tvalid), 32'd0);
        end
        checkOutput("mrst_nothing_out", 32'(obs.size() - base), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h900, 32'h901, 32'h902, 3'b111, x, y, z);
        idle(3, 3'b111);
        checkOutput("mrst_out_count", 32'(obs.size() - base), 32'd1);
        checkObs("mrst_first", base, 32'h900, 32'h901, 32'h902);

        // Randomized traffic with occasional resets
        doReset();
        repeat (800) begin
            applyStimulus(($urandom % 300) == 0,
                          ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                          $urandom, $urandom, $urandom,
                          {(($urandom % 5) != 0), (($urandom % 5) != 0), (($urandom % 5) != 0)},
                          x, y, z);
        end

        // Counter wrap
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hA, 32'hB, 32'hC, 3'b000, x, y, z);
        idle(2, 3'b000);
        @(negedge aclk);
        #1;
        force dut.joined_count = 32'hFFFFFFFF;
        count_bias             = 32'hFFFFFFFF - m_count;
        bus.m_axis_a_tready    = 1'b1;
        bus.m_axis_b_tready    = 1'b1;
        bus.m_axis_c_tready    = 1'b1;
        #1;
        checkOutput("wrap_preload", joined_count, 32'hFFFFFFFF);
        #2;
        release dut.joined_count;
        @(negedge aclk);
        #2;
        checkOutput("wrap_count", joined_count, 32'd0);
        checkOutput("wrap_tvalid_drop", 32'(bus.m_axis_a_tvalid), 32'd0);
        idle(2, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
